// File: rtl/spi_arbiter_if.sv
// Engine-side handshake between spi_arbiter (master) and the SPI shift engine (slave).
interface spi_arbiter_if;
  logic        spi_start;
  logic        spi_target;
  logic [23:0] spi_frame;
  logic        spi_done;
  logic [7:0]  spi_rdata;

  modport master (output spi_start, spi_target, spi_frame, input spi_done, spi_rdata);
  modport slave  (input spi_start, spi_target, spi_frame, output spi_done, spi_rdata);
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one SPI shift engine between DAC writes and ADC reads/writes,
// with request latching, frame formatting, done timeout and ADC readback return.
module spi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 10,
  parameter logic [2:0]  DAC_CMD        = 3'b011
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dac_request_write,
  input  logic [4:0]    dac_address,
  input  logic [11:0]   dac_data,
  input  logic          adc_request_write,
  input  logic          adc_request_read,
  input  logic [15:0]   adc_address,
  input  logic [7:0]    adc_data,
  output logic [7:0]    adc_data_readback,
  output logic          adc_readback_valid,
  output logic          spi_busy,
  spi_arbiter_if.master spi,
  input  logic          err_clear,
  output logic          overflow_err,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t          state;
  logic            dac_pend, adc_pend;
  logic [23:0]     dac_hold, adc_hold;
  logic            last_grant;            // 1 = ADC
  logic [TO_W-1:0] to_cnt;

  logic dac_pend_eff, adc_pend_eff, dac_take, adc_take, adc_take_rd;
  logic drop, to_hit, grant_adc, busy_next;
  logic unused_addr_bits;

  assign unused_addr_bits = ^adc_address[15:13];

  // A pend bit being cleared in LAUNCH counts as free, so a same-cycle pulse is accepted.
  always_comb begin
    dac_pend_eff = dac_pend & ~(state == LAUNCH && !spi.spi_target);
    adc_pend_eff = adc_pend & ~(state == LAUNCH &&  spi.spi_target);
    dac_take     = dac_request_write & ~dac_pend_eff;
    adc_take     = (adc_request_write | adc_request_read) & ~adc_pend_eff;
    adc_take_rd  = adc_request_read & ~adc_request_write;
    drop         = (dac_request_write & dac_pend_eff)
                 | ((adc_request_write | adc_request_read) & adc_pend_eff)
                 | (adc_request_write & adc_request_read);
    to_hit       = (state == WAIT) && !spi.spi_done
                 && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    grant_adc    = adc_pend & (~dac_pend | ~last_grant);
    busy_next    = dac_request_write | adc_request_write | adc_request_read
                 | dac_pend_eff | adc_pend_eff
                 | (state == LAUNCH) | ((state == WAIT) && !to_hit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      dac_pend           <= 1'b0;
      adc_pend           <= 1'b0;
      dac_hold           <= '0;
      adc_hold           <= '0;
      last_grant         <= 1'b1;
      to_cnt             <= '0;
      adc_data_readback  <= '0;
      adc_readback_valid <= 1'b0;
      spi_busy           <= 1'b0;
      spi.spi_start      <= 1'b0;
      spi.spi_target     <= 1'b0;
      spi.spi_frame      <= '0;
      overflow_err       <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      spi.spi_start      <= 1'b0;
      adc_readback_valid <= 1'b0;
      spi_busy           <= busy_next;

      case (state)
        IDLE: begin
          if (dac_pend || adc_pend) begin
            spi.spi_target <= grant_adc;
            spi.spi_frame  <= grant_adc ? adc_hold : dac_hold;
            spi.spi_start  <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (spi.spi_target) adc_pend <= 1'b0;
          else                dac_pend <= 1'b0;
          last_grant <= spi.spi_target;
          to_cnt     <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (spi.spi_done) begin
            // Frame bit 23 of an ADC frame is the read flag.
            if (spi.spi_target && spi.spi_frame[23]) begin
              adc_data_readback  <= spi.spi_rdata;
              adc_readback_valid <= 1'b1;
            end
            state <= FINISH;
          end else if (to_hit) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Capture follows the FSM so a new pulse overrides a LAUNCH-cycle clear.
      if (dac_take) begin
        dac_pend <= 1'b1;
        dac_hold <= {DAC_CMD, dac_address, dac_data, 4'b0000};
      end
      if (adc_take) begin
        adc_pend <= 1'b1;
        adc_hold <= {adc_take_rd, 2'b00, adc_address[12:0],
                     adc_take_rd ? 8'h00 : adc_data};
      end

      if (err_clear) begin
        overflow_err <= 1'b0;
        timeout_err  <= 1'b0;
      end
      if (drop)   overflow_err <= 1'b1;
      if (to_hit) timeout_err  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// Randomised request groups against a transaction-level model of grant order, frames and readback.
module tb_spi_arbiter;
  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dac_request_write, adc_request_write, adc_request_read, err_clear;
  logic [4:0]  dac_address;
  logic [11:0] dac_data;
  logic [15:0] adc_address;
  logic [7:0]  adc_data;
  logic [7:0]  adc_data_readback;
  logic        adc_readback_valid, spi_busy, overflow_err, timeout_err;

  spi_arbiter_if spi_bus();

  spi_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(6), .DAC_CMD(3'b011)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .dac_request_write  (dac_request_write),
    .dac_address        (dac_address),
    .dac_data           (dac_data),
    .adc_request_write  (adc_request_write),
    .adc_request_read   (adc_request_read),
    .adc_address        (adc_address),
    .adc_data           (adc_data),
    .adc_data_readback  (adc_data_readback),
    .adc_readback_valid (adc_readback_valid),
    .spi_busy           (spi_busy),
    .spi                (spi_bus),
    .err_clear          (err_clear),
    .overflow_err       (overflow_err),
    .timeout_err        (timeout_err)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        adc;
    logic [23:0] frm;
    logic        rd;
  } xfer_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          model_last_adc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] dac_frm(input logic [4:0] a, input logic [11:0] d);
    return 24'(32'h600000 + 32'(a) * 65536 + 32'(d) * 16);
  endfunction

  function automatic logic [23:0] adc_frm(input bit rd, input logic [15:0] a, input logic [7:0] d);
    return 24'((rd ? 32'h800000 : 32'h0) + (32'(a) % 8192) * 256 + (rd ? 32'h0 : 32'(d)));
  endfunction

  task automatic clr_inputs();
    dac_request_write = 1'b0;
    adc_request_write = 1'b0;
    adc_request_read  = 1'b0;
    err_clear         = 1'b0;
    spi_bus.spi_done  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  spi_busy, 0);
    chk({tag, "_start"}, spi_bus.spi_start, 0);
    chk({tag, "_tgt"},   spi_bus.spi_target, 0);
    chk({tag, "_frm"},   spi_bus.spi_frame, 0);
    chk({tag, "_rbv"},   adc_readback_valid, 0);
    chk({tag, "_rbd"},   adc_data_readback, 0);
    chk({tag, "_ovf"},   overflow_err, 0);
    chk({tag, "_tmo"},   timeout_err, 0);
  endtask

  task automatic wait_start(input string tag, input int exp_gap, input logic adc, input logic [23:0] frm);
    int gap = 0;
    do begin
      @(negedge clk);
      clr_inputs();
      gap++;
    end while (!spi_bus.spi_start && gap < 40);
    chk({tag, "_gap"},  gap, exp_gap);
    chk({tag, "_tgt"},  spi_bus.spi_target, adc);
    chk({tag, "_frm"},  spi_bus.spi_frame, frm);
    chk({tag, "_busy"}, spi_busy, 1);
  endtask

  task automatic finish_txn(input logic rd, input int delay, input logic [7:0] rdv, input logic more);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      clr_inputs();
      if (i == 0) chk("start_one_cycle", spi_bus.spi_start, 0);
      chk("busy_wait", spi_busy, 1);
      chk("rbv_wait", adc_readback_valid, 0);
    end
    spi_bus.spi_done  = 1'b1;
    spi_bus.spi_rdata = rdv;
    @(negedge clk);
    clr_inputs();
    chk("rbv_pulse", adc_readback_valid, rd);
    if (rd) chk("rb_data", adc_data_readback, rdv);
    chk("busy_finish", spi_busy, 1);
    @(negedge clk);
    chk("rbv_end", adc_readback_valid, 0);
    chk("busy_after", spi_busy, more);
  endtask

  // kind: 0 DAC, 1 ADC, 2 DAC+ADC together, 3 DAC with repeat pulse, 4 ADC write+read together
  task automatic do_group(input int kind, input logic [4:0] da, input logic [11:0] dd,
                          input logic [15:0] aa, input logic [7:0] ad, input bit ard,
                          input int delay, input logic [7:0] rdv);
    xfer_t q[$];
    xfer_t xd, xa;
    xd = '{adc: 1'b0, frm: dac_frm(da, dd), rd: 1'b0};
    xa = '{adc: 1'b1, frm: adc_frm(ard, aa, ad), rd: ard};
    case (kind)
      0, 3: q.push_back(xd);
      1:    q.push_back(xa);
      2: begin
        if (model_last_adc) begin q.push_back(xd); q.push_back(xa); end
        else                begin q.push_back(xa); q.push_back(xd); end
      end
      default: q.push_back('{adc: 1'b1, frm: adc_frm(1'b0, aa, ad), rd: 1'b0});
    endcase

    @(negedge clk);
    chk("busy_idle", spi_busy, 0);
    dac_request_write = (kind == 0 || kind == 2 || kind == 3);
    dac_address       = da;
    dac_data          = dd;
    adc_request_write = ((kind == 1 || kind == 2) && !ard) || kind == 4;
    adc_request_read  = ((kind == 1 || kind == 2) && ard) || kind == 4;
    adc_address       = aa;
    adc_data          = ad;
    @(negedge clk);
    clr_inputs();
    chk("busy_rise", spi_busy, 1);
    chk("start_early", spi_bus.spi_start, 0);
    if (kind == 3) begin
      dac_request_write = 1'b1;
      dac_address       = da + 5'd1;
      dac_data          = ~dd;
    end

    for (int k = 0; k < q.size(); k++) begin
      wait_start(k == 0 ? "start_first" : "start_next", 1, q[k].adc, q[k].frm);
      if (k == 0) chk("ovf_flag", overflow_err, kind >= 3);
      model_last_adc = q[k].adc;
      finish_txn(q[k].rd, delay, rdv, k < q.size() - 1);
    end

    if (kind >= 3) begin
      @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      clr_inputs();
      chk("ovf_clear", overflow_err, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ta;
    clr_inputs();
    dac_address       = '0;
    dac_data          = '0;
    adc_address       = '0;
    adc_data          = '0;
    spi_bus.spi_rdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    model_last_adc = 1'b1;

    do_group(0, 5'h07, 12'hABC, 16'h0, 8'h0, 1'b0, 30, 8'h00);
    do_group(1, 5'h00, 12'h000, 16'h0008, 8'h00, 1'b1, 5, 8'h5A);
    do_group(2, 5'h03, 12'h123, 16'h1234, 8'hC3, 1'b0, 4, 8'h00);
    do_group(2, 5'h1F, 12'hFED, 16'hFFFF, 8'h3C, 1'b0, 7, 8'h00);
    do_group(3, 5'h0A, 12'h555, 16'h0, 8'h0, 1'b0, 3, 8'h00);
    do_group(4, 5'h00, 12'h000, 16'h0ABC, 8'h99, 1'b0, 2, 8'h77);

    // Withheld done: timeout, no readback pulse.
    ta = 16'($urandom);
    @(negedge clk);
    adc_request_read = 1'b1;
    adc_address      = ta;
    @(negedge clk);
    clr_inputs();
    wait_start("tmo_start", 1, 1'b1, adc_frm(1'b1, ta, 8'h00));
    model_last_adc = 1'b1;
    for (int i = 1; i <= TO + 1; i++) begin
      @(negedge clk);
      chk("tmo_rbv", adc_readback_valid, 0);
      if (i == TO)     chk("tmo_before", timeout_err, 0);
      if (i == TO + 1) begin
        chk("tmo_set", timeout_err, 1);
        chk("tmo_busy", spi_busy, 0);
      end
    end
    err_clear = 1'b1;
    @(negedge clk);
    clr_inputs();
    chk("tmo_clear", timeout_err, 0);

    // Stray done while idle is ignored.
    spi_bus.spi_done = 1'b1;
    @(negedge clk);
    clr_inputs();
    chk("stray_rbv", adc_readback_valid, 0);
    chk("stray_busy", spi_busy, 0);

    // Reset asserted mid-WAIT.
    @(negedge clk);
    dac_request_write = 1'b1;
    dac_address       = 5'h11;
    dac_data          = 12'h0F0;
    @(negedge clk);
    clr_inputs();
    wait_start("rst_start", 1, 1'b0, dac_frm(5'h11, 12'h0F0));
    repeat (4) @(negedge clk);
    #3 reset_n = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    model_last_adc = 1'b1;
    do_group(0, 5'h02, 12'h321, 16'h0, 8'h0, 1'b0, 6, 8'h00);

    for (int n = 0; n < 40; n++) begin
      do_group(int'($urandom_range(0, 4)), 5'($urandom), 12'($urandom), 16'($urandom),
               8'($urandom), 1'($urandom), int'($urandom_range(1, 30)), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single SPI shift engine between DAC write requests and ADC write/read requests coming from the control unit.
- Latches one-cycle request pulses and arbitrates round-robin between DAC and ADC.
- Formats the 24-bit frame, launches the engine, waits for completion with a timeout, and returns ADC readback data.
- Drives the spi_busy level that the control unit polls before retiring a register instruction.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT before the transfer is abandoned.
- TO_W, 10: width of the timeout counter; TIMEOUT_CYCLES must be at most 2^TO_W.
- DAC_CMD, 3'b011: command bits prefixed to DAC frames.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- dac_request_write  in  1  one-cycle pulse: queue DAC write
- dac_address  in  5  DAC channel, sampled with the pulse
- dac_data  in  12  DAC code, sampled with the pulse
- adc_request_write  in  1  one-cycle pulse: queue ADC register write
- adc_request_read  in  1  one-cycle pulse: queue ADC register read
- adc_address  in  16  ADC register address; bits [12:0] used
- adc_data  in  8  ADC write data, sampled with the pulse
- adc_data_readback  out  8  last ADC read result
- adc_readback_valid  out  1  one-cycle pulse when adc_data_readback updates
- spi_busy  out  1  high while any request is pending or in flight
- spi_start  out  1  one-cycle launch pulse to the engine
- spi_target  out  1  0 = DAC chip select, 1 = ADC chip select; held from LAUNCH through FINISH
- spi_frame  out  24  MSB-first frame; held from LAUNCH through FINISH
- spi_done  in  1  one-cycle engine completion pulse
- spi_rdata  in  8  engine receive byte; valid with spi_done
- err_clear  in  1  clears the sticky error flags
- overflow_err  out  1  sticky: request dropped
- timeout_err  out  1  sticky: engine never signalled done

Behaviour:
- Reset (async, reset_n low):
  - All outputs are 0; state is IDLE.
  - Pending bits are cleared.
  - last_grant = ADC, so the first contention goes to the DAC.
- Request capture (every cycle, in any state):
  - dac_request_write sets dac_pend and loads {DAC_CMD, dac_address, dac_data, 4'b0000} into the DAC holding register.
  - adc_request_write sets adc_pend and loads {1'b0, 2'b00, adc_address[12:0], adc_data}, with adc_rd = 0.
  - adc_request_read sets adc_pend and loads {1'b1, 2'b00, adc_address[12:0], 8'h00}, with adc_rd = 1.
  - adc_request_write and adc_request_read in the same cycle: the write is taken, the read is dropped, and overflow_err is set.
  - A request arriving while its pend bit is already set is dropped, the holding register is unchanged, and overflow_err is set.
  - A pend bit cleared in LAUNCH may be re-set by a pulse in that same cycle; the new request wins and is not flagged.
- State machine:
  - IDLE: if neither pend bit is set, stay. If exactly one is set, grant it. If both are set, grant the side not equal to last_grant. Load spi_frame and spi_target from the granted side, then go to LAUNCH.
  - LAUNCH: spi_start = 1 for exactly one cycle. Clear the granted pend bit, update last_grant, clear the timeout counter, go to WAIT.
  - WAIT: on spi_done, go to FINISH; if target = ADC and adc_rd, capture spi_rdata. If the counter reaches TIMEOUT_CYCLES-1 without spi_done, set timeout_err and go to IDLE without a readback pulse. Otherwise increment the counter.
  - FINISH: adc_readback_valid = 1 for one cycle if the completed transfer was an ADC read. Go to IDLE.
- spi_busy:
  - Registered: high in the cycle after any request pulse.
  - Held high while any pend bit is set or state is not IDLE.
  - Low only in IDLE with both pend bits clear.
  - Back-to-back transfers keep spi_busy high with no gap.
- spi_done outside WAIT is ignored.
- err_clear clears both sticky flags. An error event in the same cycle as err_clear wins, so the flag stays set.
- Latency: from a request pulse in idle at cycle N, spi_start is high at cycle N+2.
- Reset mid-transfer: aborts immediately with no readback pulse. The engine is expected to be reset by the same reset_n.

Test Plan:
- DAC write (addr 5'h07, data 12'hABC): spi_start at N+2, spi_target 0, spi_frame 24'h67ABC0; done after 30 cycles -> spi_busy falls 2 cycles after spi_done.
- ADC read (addr 16'h0008): spi_frame 24'h800800; engine returns spi_rdata 8'h5A with done -> adc_readback_valid pulses one cycle later and adc_data_readback = 8'h5A.
- DAC and ADC write pulsed in the same cycle, issued twice in a row -> grant order DAC, ADC, DAC, ADC; spi_busy continuous throughout.
- Second DAC pulse while first still pending -> overflow_err = 1 and the original frame is sent; err_clear -> overflow_err = 0.
- spi_done withheld -> timeout_err set exactly TIMEOUT_CYCLES cycles after entering WAIT; state IDLE; no adc_readback_valid.
- reset_n low during WAIT -> all outputs 0 asynchronously; after release a new DAC request completes normally.
